// File: rtl/codebook_fetch_arbiter.sv
// codebook_fetch_arbiter
//   Owns the texture-side VRAM read port and shares it between the VQ
//   codebook-cache refill and the texel fetch unit. Refill bursts are built
//   from the latched codebook base plus the cache's current word offset.
//   Returned beats are steered to the requester that owns the burst, with one
//   strobe per beat. Refill has priority, but texel fetch is guaranteed a
//   grant after every refill burst.
//
// Ports
//   clock, reset           sole clock, synchronous active-high reset
//   cb_base/cb_wait/cb_offset  refill request side (base, busy, next word)
//   cb_valid/cb_data       codebook beat strobe and data
//   tex_req/tex_addr/tex_len/tex_ack  texel request, 1-cycle accept pulse
//   tex_valid/tex_data     texel beat strobe and data
//   vram_req/vram_addr/vram_len/vram_ack  VRAM burst request
//   vram_rvalid/vram_rdata VRAM read beats, returned in order
//   state                  debug view of the arbiter FSM
//   stat_cb_bursts/stat_tex_reqs/stat_stall  only with CBARB_STATS_EN
//
// Handshakes: vram_req is raised with a stable vram_addr/vram_len and held
// until the cycle vram_ack is sampled high; that cycle completes the request.
// tex_req is held by the requester until tex_ack pulses for one cycle; tex_addr
// and tex_len are captured on that cycle. vram_rvalid carries no back-pressure.
//
// Optional feature macro: CBARB_STATS_EN adds saturating statistics counters.
module codebook_fetch_arbiter #(
  parameter int ADDR_W    = 24,
  parameter int BURST_LEN = 8,
  parameter int TEX_MAXB  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cb_base,
  input  logic              cb_wait,
  input  logic [7:0]        cb_offset,
  output logic              cb_valid,
  output logic [63:0]       cb_data,
  input  logic              tex_req,
  input  logic [ADDR_W-1:0] tex_addr,
  input  logic [2:0]        tex_len,
  output logic              tex_ack,
  output logic              tex_valid,
  output logic [63:0]       tex_data,
  output logic              vram_req,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_len,
  input  logic              vram_ack,
  input  logic              vram_rvalid,
  input  logic [63:0]       vram_rdata,
  output logic [2:0]        state
`ifdef CBARB_STATS_EN
  ,
  output logic [15:0]       stat_cb_bursts,
  output logic [15:0]       stat_tex_reqs,
  output logic [15:0]       stat_stall
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CB_REQ  = 3'd1,
    CB_DATA = 3'd2,
    TX_REQ  = 3'd3,
    TX_DATA = 3'd4
  } state_t;

  localparam logic [8:0] BURST_BEATS = 9'(BURST_LEN);
  localparam logic [7:0] BURST_LEN8  = 8'(BURST_LEN);
  localparam logic [2:0] TEX_MAX3    = 3'(TEX_MAXB);

  state_t            st;
  logic [8:0]        beats;      // beats still owed by the current burst
  logic              last_tx;    // 1: last completed grant was texel fetch
  logic              base_held;  // codebook base latched for this refill
  logic [ADDR_W-1:0] base_q;

  logic [2:0]        tex_len_eff;
  logic [ADDR_W-1:0] cb_base_sel;
  logic [ADDR_W-1:0] cb_next_addr;

  always_comb begin
    tex_len_eff = tex_len;
    if (tex_len == 3'd0 || tex_len > TEX_MAX3) tex_len_eff = 3'd1;
    cb_base_sel  = base_held ? base_q : cb_base;
    cb_next_addr = cb_base_sel + ADDR_W'(cb_offset);
  end

  assign state = st;

  always_ff @(posedge clock) begin
    if (reset) begin
      st        <= IDLE;
      beats     <= '0;
      last_tx   <= 1'b0;
      base_held <= 1'b0;
      base_q    <= '0;
      cb_valid  <= 1'b0;
      cb_data   <= '0;
      tex_ack   <= 1'b0;
      tex_valid <= 1'b0;
      tex_data  <= '0;
      vram_req  <= 1'b0;
      vram_addr <= '0;
      vram_len  <= '0;
    end else begin
      cb_valid  <= 1'b0;
      tex_ack   <= 1'b0;
      tex_valid <= 1'b0;
      // A cleared cache starts a new refill, which samples a fresh base.
      if (!cb_wait) base_held <= 1'b0;

      case (st)
        IDLE: begin
          if (cb_wait && !(tex_req && !last_tx)) begin
            st        <= CB_REQ;
            vram_req  <= 1'b1;
            vram_addr <= cb_next_addr;
            vram_len  <= BURST_LEN8;
            base_q    <= cb_base_sel;
            base_held <= 1'b1;
          end else if (tex_req) begin
            st        <= TX_REQ;
            tex_ack   <= 1'b1;
            vram_req  <= 1'b1;
            vram_addr <= tex_addr;
            vram_len  <= {5'd0, tex_len_eff};
            beats     <= {6'd0, tex_len_eff};
          end
        end

        CB_REQ: begin
          if (vram_ack) begin
            vram_req <= 1'b0;
            st       <= CB_DATA;
            // A beat arriving together with the ack belongs to this burst.
            if (vram_rvalid) begin
              beats    <= BURST_BEATS - 9'd1;
              cb_valid <= cb_wait;
              cb_data  <= vram_rdata;
            end else begin
              beats <= BURST_BEATS;
            end
          end
        end

        CB_DATA: begin
          if (beats != 9'd0) begin
            if (vram_rvalid) begin
              beats    <= beats - 9'd1;
              cb_valid <= cb_wait;  // beats of a cancelled refill are dropped
              cb_data  <= vram_rdata;
            end
          end else if (!cb_valid) begin
            // Decide one cycle after the last strobe so cb_offset already
            // reflects every word of this burst.
            last_tx <= 1'b0;
            if (cb_wait && cb_offset != 8'd0 && !tex_req) begin
              st        <= CB_REQ;
              vram_req  <= 1'b1;
              vram_addr <= cb_next_addr;
              vram_len  <= BURST_LEN8;
            end else begin
              st <= IDLE;
            end
          end
        end

        TX_REQ: begin
          if (vram_ack) begin
            vram_req <= 1'b0;
            st       <= TX_DATA;
            if (vram_rvalid) begin
              beats     <= beats - 9'd1;
              tex_valid <= 1'b1;
              tex_data  <= vram_rdata;
            end
          end
        end

        TX_DATA: begin
          if (beats != 9'd0) begin
            if (vram_rvalid) begin
              beats     <= beats - 9'd1;
              tex_valid <= 1'b1;
              tex_data  <= vram_rdata;
            end
          end else begin
            last_tx <= 1'b1;
            st      <= IDLE;
          end
        end

        default: st <= IDLE;
      endcase
    end
  end

`ifdef CBARB_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_cb_bursts <= '0;
      stat_tex_reqs  <= '0;
      stat_stall     <= '0;
    end else begin
      if (st == CB_REQ && vram_ack && stat_cb_bursts != 16'hFFFF)
        stat_cb_bursts <= stat_cb_bursts + 16'd1;
      if (st == TX_REQ && vram_ack && stat_tex_reqs != 16'hFFFF)
        stat_tex_reqs <= stat_tex_reqs + 16'd1;
      if (tex_req && !tex_ack && stat_stall != 16'hFFFF)
        stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_codebook_fetch_arbiter.sv
// Bench for codebook_fetch_arbiter. An environment process (negedge) plays
// the VRAM controller and the codebook cache; scenario tasks (posedge + 1)
// drive requests and compare observed beats and bursts with expectations
// computed from addresses: every VRAM word at address a returns data_of(a).
module tb_codebook_fetch_arbiter;
  localparam int ADDR_W = 24;
  localparam int TEX_MAXB = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [23:0] cb_base;
  logic        cb_wait;
  logic [7:0]  cb_offset;
  logic        cb_valid;
  logic [63:0] cb_data;
  logic        tex_req;
  logic [23:0] tex_addr;
  logic [2:0]  tex_len;
  logic        tex_ack, tex_valid;
  logic [63:0] tex_data;
  logic        vram_req;
  logic [23:0] vram_addr;
  logic [7:0]  vram_len;
  logic        vram_ack, vram_rvalid;
  logic [63:0] vram_rdata;
  logic [2:0]  state;
`ifdef CBARB_STATS_EN
  logic [15:0] stat_cb_bursts, stat_tex_reqs, stat_stall;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Environment controls written by the scenario tasks.
  int          go_seq = 0;
  logic [7:0]  start_off = 8'd0;
  int          drop_at = 0;
  bit          stray_en = 1'b0;

  // Logs written by the environment, only read by the tasks.
  logic [23:0] bl_addr[$];
  logic [7:0]  bl_len[$];
  logic        bl_tex[$];
  logic [63:0] obs_cb[$];
  logic [63:0] obs_tex[$];
  int          cb_grants = 0;

  codebook_fetch_arbiter #(.ADDR_W(24), .BURST_LEN(8), .TEX_MAXB(4)) dut (
    .clock(clock), .reset(reset),
    .cb_base(cb_base), .cb_wait(cb_wait), .cb_offset(cb_offset),
    .cb_valid(cb_valid), .cb_data(cb_data),
    .tex_req(tex_req), .tex_addr(tex_addr), .tex_len(tex_len),
    .tex_ack(tex_ack), .tex_valid(tex_valid), .tex_data(tex_data),
    .vram_req(vram_req), .vram_addr(vram_addr), .vram_len(vram_len),
    .vram_ack(vram_ack), .vram_rvalid(vram_rvalid), .vram_rdata(vram_rdata),
    .state(state)
`ifdef CBARB_STATS_EN
    , .stat_cb_bursts(stat_cb_bursts), .stat_tex_reqs(stat_tex_reqs), .stat_stall(stat_stall)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] data_of(input logic [23:0] a);
    return {8'hA5, a, 8'h5A, ~a};
  endfunction

  function automatic int eff_len(input logic [2:0] l);
    if (l == 3'd0 || int'(l) > TEX_MAXB) return 1;
    return int'(l);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // ---------------- environment: VRAM controller + codebook cache ----------------
  initial begin : env
    int          r_left;
    logic [23:0] r_addr;
    logic        tex_pend;
    int          seen;
    int          cnt;
    r_left = 0; r_addr = '0; tex_pend = 1'b0; seen = 0; cnt = 0;
    cb_wait = 1'b0; cb_offset = 8'd0;
    vram_ack = 1'b0; vram_rvalid = 1'b0; vram_rdata = '0;
    forever begin
      @(negedge clock);
      vram_ack = 1'b0;
      vram_rvalid = 1'b0;
      if (reset) begin
        r_left = 0; tex_pend = 1'b0; cb_wait = 1'b0; seen = go_seq;
      end else begin
        // cache: consume one word per strobe, finish at wrap or on a forced drop
        if (cb_valid) begin
          obs_cb.push_back(cb_data);
          cb_offset = cb_offset + 8'd1;
          cnt++;
          if (cb_offset == 8'd0 || cnt == drop_at) cb_wait = 1'b0;
        end
        if (go_seq != seen) begin
          seen = go_seq; cb_offset = start_off; cnt = 0; cb_wait = 1'b1;
        end
        if (tex_valid) obs_tex.push_back(tex_data);
        if (tex_ack) tex_pend = 1'b1;
        // VRAM: random ack latency, random beat gaps, optional beat with ack
        if (r_left == 0 && vram_req && $urandom_range(0, 2) == 0) begin
          vram_ack = 1'b1;
          r_addr = vram_addr;
          r_left = int'(vram_len);
          bl_addr.push_back(vram_addr);
          bl_len.push_back(vram_len);
          bl_tex.push_back(tex_pend);
          if (!tex_pend) cb_grants++;
          tex_pend = 1'b0;
          if ($urandom_range(0, 1) == 1) begin
            vram_rvalid = 1'b1; vram_rdata = data_of(r_addr); r_addr = r_addr + 24'd1; r_left--;
          end
        end else if (r_left != 0) begin
          if ($urandom_range(0, 3) != 0) begin
            vram_rvalid = 1'b1; vram_rdata = data_of(r_addr); r_addr = r_addr + 24'd1; r_left--;
          end
        end else if (!vram_req && stray_en && $urandom_range(0, 5) == 0) begin
          vram_rvalid = 1'b1; vram_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        end
      end
    end
  end

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    n_cmp++;
    if ({cb_valid, tex_ack, tex_valid, vram_req} !== 4'b0 || cb_data !== 64'd0 || tex_data !== 64'd0 ||
        vram_addr !== 24'd0 || vram_len !== 8'd0 || state !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got cbv=%b ack=%b txv=%b req=%b addr=%h len=%0d state=%0d, want all 0",
               cb_valid, tex_ack, tex_valid, vram_req, vram_addr, vram_len, state);
    end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_refill(input string name, input logic [23:0] base, input logic [7:0] start);
    int b0, c0, nw, nb, budget;
    logic [23:0] a0, exp_a;
    b0 = bl_addr.size(); c0 = obs_cb.size();
    nw = 256 - int'(start); nb = (nw + 7) / 8;
    a0 = base + {16'd0, start};
    cb_base = base; start_off = start; go_seq++;
    budget = 0;
    while (obs_cb.size() - c0 < nw && budget < 8000) begin
      tick(1); budget++;
      // base must have been captured by the first burst
      if (bl_addr.size() > b0) cb_base = $urandom;
    end
    tick(30);
    n_cmp++;
    if (obs_cb.size() - c0 != nw) begin
      n_bad++; $display("FAIL %s_pulses: got %0d cb_valid, want %0d", name, obs_cb.size() - c0, nw);
    end
    n_cmp++;
    if (bl_addr.size() - b0 != nb) begin
      n_bad++; $display("FAIL %s_bursts: got %0d bursts, want %0d", name, bl_addr.size() - b0, nb);
    end
    for (int j = 0; j < nb && b0 + j < bl_addr.size(); j++) begin
      exp_a = a0 + 24'(8 * j);
      n_cmp++;
      if (bl_addr[b0 + j] !== exp_a || bl_len[b0 + j] !== 8'd8 || bl_tex[b0 + j] !== 1'b0) begin
        n_bad++; $display("FAIL %s_burst%0d: got addr=%h len=%0d tex=%b, want addr=%h len=8 tex=0",
                          name, j, bl_addr[b0 + j], bl_len[b0 + j], bl_tex[b0 + j], exp_a);
      end
    end
    for (int k = 0; k < nw && c0 + k < obs_cb.size(); k++) begin
      n_cmp++;
      if (obs_cb[c0 + k] !== data_of(a0 + 24'(k))) begin
        n_bad++; $display("FAIL %s_word%0d: got %h, want %h", name, k, obs_cb[c0 + k], data_of(a0 + 24'(k)));
      end
    end
  endtask

  task automatic test_texel(input string name, input logic [23:0] addr, input logic [2:0] len);
    int b0, t0, c0, e, budget;
    bit acked;
    b0 = bl_addr.size(); t0 = obs_tex.size(); c0 = obs_cb.size();
    e = eff_len(len);
    tex_addr = addr; tex_len = len; tex_req = 1'b1;
    acked = 1'b0;
    for (budget = 0; budget < 100 && !acked; budget++) begin
      tick(1);
      if (tex_ack) acked = 1'b1;
    end
    tex_req = 1'b0; tex_addr = $urandom; tex_len = 3'($urandom);
    n_cmp++;
    if (!acked) begin n_bad++; $display("FAIL %s_ack: got no tex_ack in 100 cycles, want ack", name); end
    tick(1);
    n_cmp++;
    if (tex_ack !== 1'b0) begin n_bad++; $display("FAIL %s_ack_pulse: got tex_ack=%b, want 0", name, tex_ack); end
    budget = 0;
    while (obs_tex.size() - t0 < e && budget < 300) begin tick(1); budget++; end
    tick(10);
    n_cmp++;
    if (bl_addr.size() - b0 != 1) begin
      n_bad++; $display("FAIL %s_bursts: got %0d bursts, want 1", name, bl_addr.size() - b0);
    end else begin
      n_cmp++;
      if (bl_addr[b0] !== addr || bl_len[b0] !== 8'(e)) begin
        n_bad++; $display("FAIL %s_req: got addr=%h len=%0d, want addr=%h len=%0d", name, bl_addr[b0], bl_len[b0], addr, e);
      end
    end
    n_cmp++;
    if (obs_tex.size() - t0 != e) begin
      n_bad++; $display("FAIL %s_pulses: got %0d tex_valid, want %0d", name, obs_tex.size() - t0, e);
    end
    for (int k = 0; k < e && t0 + k < obs_tex.size(); k++) begin
      n_cmp++;
      if (obs_tex[t0 + k] !== data_of(addr + 24'(k))) begin
        n_bad++; $display("FAIL %s_beat%0d: got %h, want %h", name, k, obs_tex[t0 + k], data_of(addr + 24'(k)));
      end
    end
    n_cmp++;
    if (obs_cb.size() != c0) begin
      n_bad++; $display("FAIL %s_no_cb: got %0d cb_valid, want 0", name, obs_cb.size() - c0);
    end
  endtask

  // Both requesters rise together after a refill grant: texel goes first.
  task automatic test_simultaneous();
    int b0, c0, t0, budget;
    logic [23:0] ta, base;
    b0 = bl_addr.size(); c0 = obs_cb.size(); t0 = obs_tex.size();
    ta = 24'($urandom); base = 24'($urandom);
    cb_base = base; start_off = 8'd0;
    tex_addr = ta; tex_len = 3'd2; tex_req = 1'b1; go_seq++;
    budget = 0;
    while (!tex_ack && budget < 100) begin tick(1); budget++; end
    tex_req = 1'b0;
    budget = 0;
    while (obs_cb.size() - c0 < 256 && budget < 8000) begin tick(1); budget++; end
    tick(30);
    n_cmp++;
    if (bl_addr.size() < b0 + 2 || bl_tex[b0] !== 1'b1 || bl_addr[b0] !== ta) begin
      n_bad++; $display("FAIL simul_first_tex: got %0d bursts, first tex=%b addr=%h, want tex=1 addr=%h",
                        bl_addr.size() - b0, bl_addr.size() > b0 ? bl_tex[b0] : 1'bx,
                        bl_addr.size() > b0 ? bl_addr[b0] : 24'hx, ta);
    end else begin
      n_cmp++;
      if (bl_tex[b0 + 1] !== 1'b0 || bl_addr[b0 + 1] !== base) begin
        n_bad++; $display("FAIL simul_then_cb: got tex=%b addr=%h, want tex=0 addr=%h", bl_tex[b0 + 1], bl_addr[b0 + 1], base);
      end
    end
    n_cmp++;
    if (obs_cb.size() - c0 != 256 || obs_tex.size() - t0 != 2) begin
      n_bad++; $display("FAIL simul_counts: got cb=%0d tex=%0d, want cb=256 tex=2", obs_cb.size() - c0, obs_tex.size() - t0);
    end
  endtask

  // Texel requests held during a refill wait for at most one refill burst.
  task automatic test_contention();
    int c0, t0, g_start, g0, budget, nreq;
    logic [63:0] exp_q[$];
    logic [23:0] base, ta;
    logic [2:0] tl;
    base = 24'($urandom);
    c0 = obs_cb.size(); t0 = obs_tex.size(); g_start = cb_grants;
    cb_base = base; start_off = 8'd0; go_seq++;
    tick(4);
    nreq = 6;
    for (int r = 0; r < nreq; r++) begin
      ta = 24'($urandom); tl = 3'($urandom_range(0, 7));
      tex_addr = ta; tex_len = tl; tex_req = 1'b1;
      g0 = cb_grants;
      budget = 0;
      while (!tex_ack && budget < 200) begin tick(1); budget++; end
      n_cmp++;
      if (!tex_ack || cb_grants - g0 > 1) begin
        n_bad++; $display("FAIL contention_wait%0d: got ack=%b after %0d cb bursts, want ack after <=1", r, tex_ack, cb_grants - g0);
      end
      if (r == 0) begin
        n_cmp++;
        if (cb_grants - g_start < 1) begin
          n_bad++; $display("FAIL contention_first_ack: got %0d cb bursts before ack, want >=1", cb_grants - g_start);
        end
      end
      for (int k = 0; k < eff_len(tl); k++) exp_q.push_back(data_of(ta + 24'(k)));
      tick(1);
    end
    tex_req = 1'b0;
    budget = 0;
    while ((obs_cb.size() - c0 < 256 || obs_tex.size() - t0 < exp_q.size()) && budget < 10000) begin
      tick(1); budget++;
    end
    tick(30);
    n_cmp++;
    if (obs_cb.size() - c0 != 256 || obs_tex.size() - t0 != exp_q.size()) begin
      n_bad++; $display("FAIL contention_counts: got cb=%0d tex=%0d, want cb=256 tex=%0d",
                        obs_cb.size() - c0, obs_tex.size() - t0, exp_q.size());
    end
    for (int k = 0; k < 256 && c0 + k < obs_cb.size(); k++) begin
      n_cmp++;
      if (obs_cb[c0 + k] !== data_of(base + 24'(k))) begin
        n_bad++; $display("FAIL contention_cb%0d: got %h, want %h", k, obs_cb[c0 + k], data_of(base + 24'(k)));
      end
    end
    for (int k = 0; k < exp_q.size() && t0 + k < obs_tex.size(); k++) begin
      n_cmp++;
      if (obs_tex[t0 + k] !== exp_q[k]) begin
        n_bad++; $display("FAIL contention_tex%0d: got %h, want %h", k, obs_tex[t0 + k], exp_q[k]);
      end
    end
  endtask

  // Cache cleared after 3 beats: the rest of the burst is dropped silently.
  task automatic test_cb_drop();
    int b0, c0, budget, req_cycles;
    logic [23:0] base;
    base = 24'($urandom);
    b0 = bl_addr.size(); c0 = obs_cb.size();
    drop_at = 3; cb_base = base; start_off = 8'd0; go_seq++;
    budget = 0;
    while (obs_cb.size() - c0 < 3 && budget < 300) begin tick(1); budget++; end
    tick(60);
    n_cmp++;
    if (obs_cb.size() - c0 != 3) begin
      n_bad++; $display("FAIL drop_pulses: got %0d cb_valid, want 3", obs_cb.size() - c0);
    end
    for (int k = 0; k < 3 && c0 + k < obs_cb.size(); k++) begin
      n_cmp++;
      if (obs_cb[c0 + k] !== data_of(base + 24'(k))) begin
        n_bad++; $display("FAIL drop_word%0d: got %h, want %h", k, obs_cb[c0 + k], data_of(base + 24'(k)));
      end
    end
    req_cycles = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (vram_req) req_cycles++;
    end
    n_cmp++;
    if (bl_addr.size() - b0 != 1 || req_cycles != 0 || state !== 3'd0) begin
      n_bad++; $display("FAIL drop_idle: got bursts=%0d req_cycles=%0d state=%0d, want 1/0/0",
                        bl_addr.size() - b0, req_cycles, state);
    end
    drop_at = 0;
  endtask

  task automatic test_reset_mid();
    int budget;
    cb_base = 24'($urandom); start_off = 8'd0; go_seq++;
    budget = 0;
    while (!cb_valid && budget < 300) begin tick(1); budget++; end
    n_cmp++;
    if (!cb_valid) begin n_bad++; $display("FAIL rstmid_setup: got no cb_valid, want a codebook beat"); end
    reset = 1'b1;
    tick(1);
    n_cmp++;
    if ({cb_valid, tex_ack, tex_valid, vram_req} !== 4'b0 || cb_data !== 64'd0 || tex_data !== 64'd0 ||
        vram_addr !== 24'd0 || vram_len !== 8'd0 || state !== 3'd0) begin
      n_bad++; $display("FAIL rstmid_outputs: got cbv=%b req=%b addr=%h len=%0d state=%0d, want all 0",
                        cb_valid, vram_req, vram_addr, vram_len, state);
    end
`ifdef CBARB_STATS_EN
    n_cmp++;
    if (stat_cb_bursts !== 16'd0 || stat_tex_reqs !== 16'd0 || stat_stall !== 16'd0) begin
      n_bad++; $display("FAIL rstmid_stats: got %0d/%0d/%0d, want 0/0/0", stat_cb_bursts, stat_tex_reqs, stat_stall);
    end
`endif
    tick(1);
    reset = 1'b0;
    tick(3);
`ifdef CBARB_STATS_EN
    test_refill("stats_refill", 24'h001000, 8'd0);
    n_cmp++;
    if (stat_cb_bursts !== 16'd32) begin
      n_bad++; $display("FAIL stats_cb_bursts: got %0d, want 32", stat_cb_bursts);
    end
`endif
  endtask

  // ---------------- sequence ----------------
  initial begin
    reset = 1'b1; cb_base = '0; tex_req = 1'b0; tex_addr = '0; tex_len = 3'd1;
    test_reset();
    test_simultaneous();
    test_refill("refill_1000", 24'h001000, 8'd0);
    test_texel("tex_wrap", 24'hFFFFFE, 3'd4);
    test_texel("tex_len0", 24'($urandom), 3'd0);
    test_texel("tex_len7", 24'($urandom), 3'd7);
    test_refill("refill_wrap", 24'hFFFFF8, 8'd16);
    stray_en = 1'b1;
    for (int i = 0; i < 4; i++) test_texel("tex_rand", 24'($urandom), 3'($urandom_range(0, 7)));
    test_refill("refill_rand", 24'($urandom), 8'(8 * $urandom_range(0, 31)));
    test_contention();
    test_cb_drop();
    stray_en = 1'b0;
    test_reset_mid();
    test_texel("tex_after_rst", 24'($urandom), 3'd3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
